dpram_stream_reader: RTL and testbench

DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

---
 rtl/dpram_stream_pkg.sv | 15 +
 rtl/stream_skid_fifo.sv | 61 ++++++
 rtl/dpram_stream_reader.sv | 120 ++++++++++++
 tb/tb_dpram_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_stream_pkg.sv
// Shared defaults and state encoding for the DPRAM stream reader.
package dpram_stream_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int LEN_W      = DEF_ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid FIFO carrying a data word plus its last-of-burst flag.
// Valid/ready on both sides; occupancy is exported so the producer can
// budget its outstanding reads.
module stream_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [1:0]       occupancy
);

  logic [WIDTH:0] slot_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     count_q;
  logic           push;
  logic           pop;
  logic           head_last;

  assign s_ready   = (count_q != 2'd2);
  assign m_valid   = (count_q != 2'd0);
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign occupancy = count_q;

  // The head entry drives the output directly, so it holds still under stall.
  assign {head_last, m_data} = slot_q[rd_ptr_q];
  assign m_last = m_valid && head_last;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only two entries, and they feed an output that must read 0 in
      // reset, so clearing them is cheap and worthwhile; larger RAMs are not reset.
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_ptr_q] <= {s_last, s_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dpram_stream_reader.sv
// Reads a burst of consecutive words from one synchronous DPRAM port and
// presents them as a valid/ready stream with a last-word marker.
module dpram_stream_reader
  import dpram_stream_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LENGTH,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [DATA_W-1:0] RAM_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W:0]   len_sat;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              start_ok;
  logic              issue;
  logic              last_issue;
  logic              xfer;
  logic              fifo_ready;
  logic [1:0]        occupancy;
  logic [1:0]        slots_used;

  assign len_sat  = (LENGTH > MAX_LEN) ? MAX_LEN : LENGTH;
  assign start_ok = (state_q == ST_IDLE) && START;
  assign xfer     = M_VALID && M_READY;

  // A word leaving the FIFO this cycle frees its slot immediately; without
  // that the two-slot budget could not sustain one word per cycle.
  assign slots_used = occupancy + {1'b0, inflight_q} - {1'b0, xfer};
  assign issue      = (state_q == ST_READ) && (slots_used < 2'd2);
  assign last_issue = issue && (remaining_q == (ADDR_W + 1)'(1));

  // The address is presented in the cycle the read issues and parks otherwise.
  assign RAM_ADDR = issue ? next_addr_q : last_addr_q;

  assign BUSY = (state_q != ST_IDLE);
  assign DONE = (state_q == ST_FINISH);

  // Burst bookkeeping: next address, reads left to issue, read in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      next_addr_q     <= '0;
      last_addr_q     <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, regardless of statement order.
      if (start_ok) begin
        next_addr_q <= BASE_ADDR;
        remaining_q <= len_sat;
      end else if (issue) begin
        next_addr_q <= next_addr_q + ADDR_W'(1);
        last_addr_q <= next_addr_q;
        remaining_q <= remaining_q - (ADDR_W + 1)'(1);
      end
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (START) state_d = (len_sat == '0) ? ST_FINISH : ST_READ;
      ST_READ:   if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN:  if (xfer && M_LAST) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  stream_skid_fifo #(
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .s_valid  (inflight_q),
    .s_ready  (fifo_ready),
    .s_data   (RAM_DATA),
    .s_last   (inflight_last_q),
    .m_valid  (M_VALID),
    .m_ready  (M_READY),
    .m_data   (M_DATA),
    .m_last   (M_LAST),
    .occupancy(occupancy)
  );

  // The read budget guarantees returning data always finds a free slot.
  a_no_overflow : assert property (@(posedge CLK) disable iff (!RESET_N)
    inflight_q |-> fifo_ready);

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Self-checking bench for dpram_stream_reader: a synchronous RAM model
// preloaded with 16'h1000 + address, and per-burst expected-word queues.
module tb_dpram_stream_reader;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [7:0]  BASE_ADDR;
  logic [8:0]  LENGTH;
  logic [7:0]  RAM_ADDR;
  logic [15:0] RAM_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic [15:0] M_DATA;
  logic        M_LAST;
  logic        BUSY;
  logic        DONE;

  logic [15:0] mem [256];
  int n_compared   = 0;
  int n_mismatched = 0;

  dpram_stream_reader #(
    .ADDR_W(8),
    .DATA_W(16)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .BASE_ADDR(BASE_ADDR),
    .LENGTH   (LENGTH),
    .RAM_ADDR (RAM_ADDR),
    .RAM_DATA (RAM_DATA),
    .M_VALID  (M_VALID),
    .M_READY  (M_READY),
    .M_DATA   (M_DATA),
    .M_LAST   (M_LAST),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  // Synchronous read port: data one cycle after the address.
  always @(posedge CLK) RAM_DATA <= mem[RAM_ADDR];

  // Drive one burst, check every transfer against the expected word list.
  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  // mode 0: ready always high, 1: ready 1-0-1-0, 2: random ready.
  task automatic run_burst(input logic [7:0] base, input logic [8:0] len,
                           input int mode, input int restart_at,
                           output int n_words, output int done_cyc,
                           output int first_valid);
    logic [16:0] exp_q[$];
    logic [16:0] exp_w;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    int          eff;
    int          budget;
    eff = (len > 9'd256) ? 256 : int'(len);
    for (int i = 0; i < eff; i++)
      exp_q.push_back({(i == eff - 1), 16'h1000 + 16'((int'(base) + i) % 256)});
    n_words = 0; done_cyc = -1; first_valid = -1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    budget = 4 * eff + 40;
    for (int t = 0; t <= budget; t++) begin
      @(negedge CLK);
      START = (t == 0) || (t == restart_at);
      if (t == 0) begin
        BASE_ADDR = base; LENGTH = len;
      end else if (t == restart_at) begin
        BASE_ADDR = 8'h80; LENGTH = 9'd5;
      end
      case (mode)
        0:       M_READY = 1'b1;
        1:       M_READY = (t % 2 == 0);
        default: M_READY = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (t == 1 && eff > 0) begin
        n_compared++;
        if (RAM_ADDR !== base) begin
          n_mismatched++;
          $display("FAIL first_addr: got %h want %h", RAM_ADDR, base);
        end
      end
      if (prev_stall) begin
        n_compared++;
        if (M_VALID !== 1'b1 || M_DATA !== prev_data || M_LAST !== prev_last) begin
          n_mismatched++;
          $display("FAIL stall_hold t=%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   t, M_VALID, M_DATA, M_LAST, prev_data, prev_last);
        end
      end
      if (M_VALID === 1'b1 && first_valid < 0) first_valid = t;
      if (M_VALID === 1'b1 && M_READY) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("FAIL extra_word t=%0d: got %h want none", t, M_DATA);
        end else begin
          exp_w = exp_q.pop_front();
          if (M_DATA !== exp_w[15:0] || M_LAST !== exp_w[16]) begin
            n_mismatched++;
            $display("FAIL word%0d: got d=%h l=%b want d=%h l=%b",
                     n_words, M_DATA, M_LAST, exp_w[15:0], exp_w[16]);
          end
          if (mode == 0) begin
            n_compared++;
            if (t != 3 + n_words) begin
              n_mismatched++;
              $display("FAIL word%0d_cycle: got %0d want %0d", n_words, t, 3 + n_words);
            end
          end
        end
        n_words++;
      end
      prev_stall = (M_VALID === 1'b1) && !M_READY;
      prev_data  = M_DATA;
      prev_last  = M_LAST;
      if (DONE === 1'b1) begin
        done_cyc = t;
        break;
      end
    end
    START = 1'b0;
    n_compared++;
    if (done_cyc < 0) begin
      n_mismatched++;
      $display("FAIL done_timeout: got no DONE want DONE within %0d cycles", budget);
    end
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL words_missing: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_compared++;
    if (M_VALID !== 1'b0 || M_LAST !== 1'b0 || M_DATA !== 16'h0 ||
        RAM_ADDR !== 8'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_mismatched++;
      $display("FAIL %s: got v=%b l=%b d=%h a=%h busy=%b done=%b want all 0",
               tag, M_VALID, M_LAST, M_DATA, RAM_ADDR, BUSY, DONE);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; START = 1'b0; BASE_ADDR = 8'h55; LENGTH = 9'd7; M_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1 check_reset_outputs("reset_state");
    @(negedge CLK) RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    #1 check_reset_outputs("idle_after_release");
  endtask

  task automatic test_basic();
    int nw, dc, fv;
    run_burst(8'h10, 9'd4, 0, -1, nw, dc, fv);
    n_compared++;
    if (nw != 4 || fv != 3 || dc != 7) begin
      n_mismatched++;
      $display("FAIL basic: got words=%0d first=%0d done=%0d want 4 3 7", nw, fv, dc);
    end
  endtask

  task automatic test_wrap();
    int nw, dc, fv;
    run_burst(8'hFE, 9'd4, 0, -1, nw, dc, fv);
    n_compared++;
    if (nw != 4) begin
      n_mismatched++;
      $display("FAIL wrap_count: got %0d want 4", nw);
    end
  endtask

  task automatic test_stall_toggle();
    int nw, dc, fv;
    run_burst(8'h00, 9'd8, 1, -1, nw, dc, fv);
    n_compared++;
    if (nw != 8) begin
      n_mismatched++;
      $display("FAIL toggle_count: got %0d want 8", nw);
    end
  endtask

  task automatic test_length_bounds();
    int nw, dc, fv;
    run_burst(8'h33, 9'd0, 0, -1, nw, dc, fv);
    n_compared++;
    if (nw != 0 || dc != 1 || fv != -1) begin
      n_mismatched++;
      $display("FAIL len0: got words=%0d done=%0d first=%0d want 0 1 -1", nw, dc, fv);
    end
    run_burst(8'h37, 9'd300, 0, -1, nw, dc, fv);
    n_compared++;
    if (nw != 256 || dc != 259) begin
      n_mismatched++;
      $display("FAIL len300: got words=%0d done=%0d want 256 259", nw, dc);
    end
    run_burst(8'hC0, 9'd256, 2, -1, nw, dc, fv);
    n_compared++;
    if (nw != 256) begin
      n_mismatched++;
      $display("FAIL len256_random: got %0d want 256", nw);
    end
  endtask

  task automatic test_start_while_busy();
    int nw, dc, fv;
    run_burst(8'h40, 9'd6, 2, 4, nw, dc, fv);
    n_compared++;
    if (nw != 6) begin
      n_mismatched++;
      $display("FAIL restart_ignored: got %0d want 6", nw);
    end
  endtask

  task automatic test_reset_mid_burst();
    int nw, dc, fv;
    int rise = -1;
    logic fired = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK);
      START = (t == 0); BASE_ADDR = 8'h00; LENGTH = 9'd16; M_READY = 1'b1;
      if (rise >= 0 && t == rise + 2) begin
        RESET_N = 1'b0; fired = 1'b1;
        break;
      end
      #1;
      if (M_VALID === 1'b1 && rise < 0) rise = t;
    end
    START = 1'b0;
    n_compared++;
    if (!fired) begin
      n_mismatched++;
      $display("FAIL midreset_valid: got no M_VALID want M_VALID rise");
      RESET_N = 1'b0;
    end
    #1 check_reset_outputs("midreset_state");
    @(negedge CLK);
    @(negedge CLK) RESET_N = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge CLK);
      #1;
      n_compared++;
      if (M_VALID !== 1'b0 || BUSY !== 1'b0) begin
        n_mismatched++;
        $display("FAIL midreset_quiet t=%0d: got v=%b busy=%b want 0 0", t, M_VALID, BUSY);
      end
    end
    run_burst(8'h20, 9'd2, 0, -1, nw, dc, fv);
    n_compared++;
    if (nw != 2) begin
      n_mismatched++;
      $display("FAIL midreset_next: got %0d want 2", nw);
    end
  endtask

  task automatic test_random();
    int nw, dc, fv;
    logic [7:0] b;
    logic [8:0] l;
    for (int r = 0; r < 8; r++) begin
      b = 8'($urandom_range(0, 255));
      l = 9'($urandom_range(1, 40));
      run_burst(b, l, 2, -1, nw, dc, fv);
      n_compared++;
      if (nw != int'(l)) begin
        n_mismatched++;
        $display("FAIL random%0d_count: got %0d want %0d", r, nw, l);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_stall_toggle();
    test_length_bounds();
    test_start_while_busy();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
